// File: rtl/output_channel_reserving_buffer_pkg.sv
// Shared widths and the channel entry layout for the PE output channel buffer.
package output_channel_reserving_buffer_pkg;

  localparam int TIA_WORD_WIDTH                 = 32;
  localparam int TIA_TAG_WIDTH                  = 3;
  // Must be wide enough to hold the value DEPTH.
  localparam int TIA_CHANNEL_BUFFER_COUNT_WIDTH = 3;

  typedef struct packed {
    logic [TIA_TAG_WIDTH-1:0]  tag;
    logic [TIA_WORD_WIDTH-1:0] word;
  } channel_entry_t;

endpackage

// File: rtl/output_channel_reservation_counter.sv
// Tracks reservations between trigger and writeback, qualifies writeback
// enqueues and latches a sticky error on any protocol violation.
module output_channel_reservation_counter #(
  parameter  int MAX_IN_FLIGHT = 2,
  localparam int RES_W         = $clog2(MAX_IN_FLIGHT + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             reserve,
  input  logic             cancel,
  input  logic             enq,
  input  logic             fifo_ovf,
  output logic [RES_W-1:0] res,
  output logic             enq_ok,
  output logic             error
);

  localparam logic [RES_W:0] MAX_RES = (RES_W + 1)'(MAX_IN_FLIGHT);

  logic [RES_W:0] up;
  logic [RES_W:0] dn;
  logic [RES_W:0] res_next;
  logic           underflow;
  logic           res_ovf;
  logic           violation;

  // Covers unreserved enqueue, enq+cancel at res==1 and any cancel past zero.
  assign up        = {1'b0, res} + (RES_W + 1)'(reserve);
  assign dn        = (RES_W + 1)'(enq) + (RES_W + 1)'(cancel);
  assign underflow = up < dn;
  assign res_next  = up - dn;
  assign res_ovf   = !underflow && (res_next > MAX_RES);
  assign violation = underflow || res_ovf || fifo_ovf;
  assign enq_ok    = enq && !violation;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res   <= '0;
      error <= 1'b0;
    end else if (violation) begin
      error <= 1'b1;
    end else begin
      res <= res_next[RES_W-1:0];
    end
  end

endmodule

// File: rtl/output_channel_reserving_buffer.sv
// Producer-side output channel FIFO whose full status charges in-flight reservations.
// Optional same-cycle bypass when empty: define TIA_OUTPUT_CHANNEL_BYPASS_EN.
module output_channel_reserving_buffer
  import output_channel_reserving_buffer_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int MAX_IN_FLIGHT = 2
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic                                      reserve,
  input  logic                                      cancel,
  input  logic                                      enq,
  input  logic [TIA_WORD_WIDTH-1:0]                 enq_data,
  input  logic [TIA_TAG_WIDTH-1:0]                  enq_tag,
  output logic                                      full_status,
  output logic [TIA_CHANNEL_BUFFER_COUNT_WIDTH-1:0] count,
  output logic                                      out_valid,
  output logic [TIA_WORD_WIDTH-1:0]                 out_data,
  output logic [TIA_TAG_WIDTH-1:0]                  out_tag,
  input  logic                                      out_ready,
  output logic                                      error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int RES_W = $clog2(MAX_IN_FLIGHT + 1);
  localparam int CNT_W = TIA_CHANNEL_BUFFER_COUNT_WIDTH;

  channel_entry_t mem [DEPTH];
  channel_entry_t enq_entry;
  channel_entry_t head;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [RES_W-1:0] res;
  logic             full_flag;
  logic             fifo_ovf;
  logic             enq_ok;
  logic             bypass;
  logic             head_valid;
  logic             deq;
  logic             wr_en;
  logic             rd_adv;

  assign enq_entry = channel_entry_t'{tag: enq_tag, word: enq_data};
  assign full_flag = count_q == CNT_W'(DEPTH);
  // A full buffer always presents a valid head, so out_ready alone decides the dequeue.
  assign fifo_ovf  = enq && full_flag && !out_ready;

  output_channel_reservation_counter #(
    .MAX_IN_FLIGHT (MAX_IN_FLIGHT)
  ) u_res_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .reserve  (reserve),
    .cancel   (cancel),
    .enq      (enq),
    .fifo_ovf (fifo_ovf),
    .res      (res),
    .enq_ok   (enq_ok),
    .error    (error)
  );

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    bypass = 1'b0;
`ifdef TIA_OUTPUT_CHANNEL_BYPASS_EN
    bypass = enq_ok && (count_q == '0);
`endif
    head_valid = (count_q != '0) || bypass;
    head       = bypass ? enq_entry : mem[rd_ptr];
    deq        = head_valid && out_ready;
    wr_en      = enq_ok && !(bypass && out_ready);
    rd_adv     = deq && !bypass;
  end

  assign out_valid   = head_valid;
  assign out_data    = head_valid ? head.word : '0;
  assign out_tag     = head_valid ? head.tag  : '0;
  assign count       = count_q;
  assign full_status = (int'(count_q) + int'(res)) >= DEPTH;

  // NOTE: storage is not reset; the head is masked while empty, so stale
  // contents are never observable.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= enq_entry;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_adv);
    end
  end

endmodule
